// File: rtl/ks_pkg.sv
// ks_pkg -- shared constants, state type and LFSR step function for the
// Karplus-Strong voice controller.
//
// Contents:
//   SAMPLE_W, ADDR_W  : sample and delay-line address widths
//   LEN_DEFAULT       : default delay-line length in samples
//   LFSR_MASK/SEED    : Galois LFSR feedback mask and power-on seed
//   ks_state_t        : controller FSM states
//   lfsr_step()       : one right-shifting Galois LFSR step
package ks_pkg;

   localparam int SAMPLE_W    = 16;
   localparam int ADDR_W      = 8;
   localparam int LEN_DEFAULT = 218;

   localparam logic [15:0] LFSR_MASK = 16'hB400;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      WAIT,
      CALC,
      WRITE
   } ks_state_t;

   // The controller needs the post-step value one cycle early to register
   // the fill write data, so the step lives here and is shared with the LFSR.
   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return (v >> 1) ^ (v[0] ? LFSR_MASK : 16'h0000);
   endfunction

endpackage

// File: rtl/ks_noise_lfsr.sv
// ks_noise_lfsr -- 16-bit Galois LFSR noise source used to fill the delay line.
//
// Ports:
//   clk     in   clock
//   reset   in   asynchronous active-low reset, reloads the seed
//   advance in   step the LFSR at the next clock edge
//   value   out  current LFSR state
module ks_noise_lfsr
   import ks_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        advance,
   output logic [15:0] value
);

   logic [15:0] value_q;
   logic [15:0] value_d;

   always_comb begin
      value_d = value_q;
      if (advance) begin
         value_d = lfsr_step(value_q);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         value_q <= LFSR_SEED;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/ks_voice_ctrl.sv
// ks_voice_ctrl -- Karplus-Strong plucked-string voice controller. Fills an
// external delay line with noise on pluck, then on every sample_tick averages
// two adjacent entries, optionally decays the result, writes it back and
// presents it as the next audio sample.
//
// Ports:
//   clk           in   clock
//   reset         in   asynchronous active-low reset
//   pluck         in   start a new note (noise fill)
//   sample_tick   in   request the next output sample
//   rf_sample1    in   delay-line entry at rf_addr-1 (wraps to LEN-1)
//   rf_sample2    in   delay-line entry at rf_addr
//   rf_addr       out  delay-line read/write address
//   rf_write      out  delay-line write enable
//   rf_wdata      out  delay-line write data
//   sample_out    out  last produced sample, held between updates
//   sample_valid  out  one-cycle pulse when sample_out updates
//   busy          out  high while filling
//   overrun       out  sticky: a sample_tick was dropped
module ks_voice_ctrl
   import ks_pkg::*;
#(
   parameter int LEN      = LEN_DEFAULT,
   parameter int DECAY_SH = 0,
   parameter int AMP_SH   = 2
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        pluck,
   input  logic        sample_tick,
   input  logic [15:0] rf_sample1,
   input  logic [15:0] rf_sample2,
   output logic [7:0]  rf_addr,
   output logic        rf_write,
   output logic [15:0] rf_wdata,
   output logic [15:0] sample_out,
   output logic        sample_valid,
   output logic        busy,
   output logic        overrun
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LEN - 1);

   ks_state_t state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
   logic rf_write_q, rf_write_d;
   logic [15:0] rf_wdata_q, rf_wdata_d;
   logic [15:0] sample_out_q, sample_out_d;
   logic sample_valid_q, sample_valid_d;
   logic overrun_q, overrun_d;

   logic lfsr_advance;
   logic [15:0] lfsr_value;
   logic [15:0] lfsr_next;
   logic signed [15:0] noise;
   logic [16:0] sum17;
   logic signed [15:0] avg;
   logic signed [15:0] y;

   ks_noise_lfsr u_lfsr (
      .clk     (clk),
      .reset   (reset),
      .advance (lfsr_advance),
      .value   (lfsr_value)
   );

   // Datapath. The write outputs are registered, so the fill data is taken
   // from the LFSR value that will be current during the next cycle.
   // avg is the 17-bit sum shifted right by one, i.e. bits [16:1].
   always_comb begin
      lfsr_advance = (state_q == FILL);
      lfsr_next    = lfsr_advance ? lfsr_step(lfsr_value) : lfsr_value;
      noise        = $signed(lfsr_next) >>> AMP_SH;
      sum17        = {rf_sample1[15], rf_sample1} + {rf_sample2[15], rf_sample2};
      avg          = $signed(sum17[16:1]);
      if (DECAY_SH > 0) begin
         y = avg - (avg >>> DECAY_SH);
      end else begin
         y = avg;
      end
   end

   // Next-state logic. pluck overrides everything, including a coincident
   // tick, which is then dropped without flagging overrun.
   always_comb begin
      state_d        = state_q;
      ptr_d          = ptr_q;
      overrun_d      = overrun_q;
      sample_out_d   = sample_out_q;
      sample_valid_d = 1'b0;
      if (pluck) begin
         state_d   = FILL;
         ptr_d     = '0;
         overrun_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            FILL: begin
               if (sample_tick) begin
                  overrun_d = 1'b1;
               end
               if (ptr_q == LAST) begin
                  ptr_d   = '0;
                  state_d = WAIT;
               end else begin
                  ptr_d = ptr_q + 1'b1;
               end
            end
            WAIT: begin
               if (sample_tick) begin
                  state_d = CALC;
               end
            end
            CALC: begin
               if (sample_tick) begin
                  overrun_d = 1'b1;
               end
               state_d = WRITE;
            end
            WRITE: begin
               if (sample_tick) begin
                  overrun_d = 1'b1;
               end
               sample_out_d   = rf_wdata_q;
               sample_valid_d = 1'b1;
               ptr_d          = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
               state_d        = WAIT;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Registered delay-line outputs, decoded from the next state.
   always_comb begin
      rf_addr_d  = ptr_d;
      rf_write_d = 1'b0;
      rf_wdata_d = '0;
      case (state_d)
         FILL: begin
            rf_write_d = 1'b1;
            rf_wdata_d = noise;
         end
         WRITE: begin
            rf_write_d = 1'b1;
            rf_wdata_d = y;
         end
         default: begin
            rf_write_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         ptr_q          <= '0;
         rf_addr_q      <= '0;
         rf_write_q     <= 1'b0;
         rf_wdata_q     <= '0;
         sample_out_q   <= '0;
         sample_valid_q <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         ptr_q          <= ptr_d;
         rf_addr_q      <= rf_addr_d;
         rf_write_q     <= rf_write_d;
         rf_wdata_q     <= rf_wdata_d;
         sample_out_q   <= sample_out_d;
         sample_valid_q <= sample_valid_d;
         overrun_q      <= overrun_d;
      end
   end

   // A pluck arriving during WRITE abandons that write in the same cycle.
   assign rf_write     = rf_write_q & ~(pluck & (state_q == WRITE));
   assign rf_addr      = rf_addr_q;
   assign rf_wdata     = rf_wdata_q;
   assign sample_out   = sample_out_q;
   assign sample_valid = sample_valid_q;
   assign busy         = (state_q == FILL);
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_ks_voice_ctrl.sv
// tb_ks_voice_ctrl -- scoreboard bench for ks_voice_ctrl. Stimulus tasks push
// expected delay-line writes and output samples (with their expected cycle)
// into queues; a negedge monitor pops and compares whenever the DUT writes or
// pulses sample_valid. A second instance with DECAY_SH=3 and constant inputs
// covers the decay path.
module tb_ks_voice_ctrl;

   localparam int LEN  = 218;
   localparam int LEN2 = 8;

   typedef struct {
      int         cyc;
      logic [7:0] addr;
      logic [15:0] data;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, pluck, sample_tick;
   logic [15:0] rf_sample1, rf_sample2, rf_wdata, sample_out;
   logic [7:0] rf_addr;
   logic rf_write, sample_valid, busy, overrun;

   logic pluck2, tick2;
   logic [15:0] c800;
   logic [15:0] rf_wdata2, sample_out2;
   logic [7:0] rf_addr2;
   logic rf_write2, sample_valid2, busy2, overrun2;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;
   int busy_cnt = 0;

   exp_t wq[$];
   exp_t sq[$];
   exp_t sq2[$];

   logic [15:0] mem [0:LEN-1];
   logic [15:0] exp_mem [0:LEN-1];
   int exp_ptr = 0;
   logic [15:0] mdl_lfsr = 16'hACE1;

   logic poke_en = 1'b0;
   logic [7:0] poke_addr = '0;
   logic [15:0] poke_data = '0;

   ks_voice_ctrl #(.LEN(LEN), .DECAY_SH(0), .AMP_SH(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .pluck        (pluck),
      .sample_tick  (sample_tick),
      .rf_sample1   (rf_sample1),
      .rf_sample2   (rf_sample2),
      .rf_addr      (rf_addr),
      .rf_write     (rf_write),
      .rf_wdata     (rf_wdata),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .busy         (busy),
      .overrun      (overrun)
   );

   ks_voice_ctrl #(.LEN(LEN2), .DECAY_SH(3), .AMP_SH(2)) dut2 (
      .clk          (clk),
      .reset        (reset),
      .pluck        (pluck2),
      .sample_tick  (tick2),
      .rf_sample1   (c800),
      .rf_sample2   (c800),
      .rf_addr      (rf_addr2),
      .rf_write     (rf_write2),
      .rf_wdata     (rf_wdata2),
      .sample_out   (sample_out2),
      .sample_valid (sample_valid2),
      .busy         (busy2),
      .overrun      (overrun2)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Delay-line memory model with a bench-side poke port.
   always @(posedge clk) begin
      if (rf_write) mem[rf_addr] <= rf_wdata;
      if (poke_en) mem[poke_addr] <= poke_data;
   end

   always_comb begin
      int i1;
      i1 = (rf_addr == 8'd0) ? LEN - 1 : int'(rf_addr) - 1;
      rf_sample2 = mem[rf_addr];
      rf_sample1 = mem[i1];
   end

   task automatic report_fail(input string name, input string msg);
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s: %s", name, msg);
   endtask

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   function automatic logic [15:0] model_step(input logic [15:0] v);
      if (v[0]) return (v >> 1) ^ 16'hB400;
      return v >> 1;
   endfunction

   function automatic logic [15:0] calc_y(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {a[15], a} + {b[15], b};
      return s[16:1];
   endfunction

   // Monitor: compare every DUT write / sample against the queued expectation.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (busy) busy_cnt++;
      if (rf_write) begin
         if (wq.size() == 0) begin
            report_fail("unexpected_write", $sformatf("addr %0d data %0h", rf_addr, rf_wdata));
         end else begin
            e = wq.pop_front();
            check_output("write_cycle", cyc, e.cyc);
            check_output("write_addr", {24'd0, rf_addr}, {24'd0, e.addr});
            check_output("write_data", {16'd0, rf_wdata}, {16'd0, e.data});
         end
      end
      if (sample_valid) begin
         if (sq.size() == 0) begin
            report_fail("unexpected_sample", $sformatf("sample_out %0h", sample_out));
         end else begin
            e = sq.pop_front();
            check_output("sample_cycle", cyc, e.cyc);
            check_output("sample_data", {16'd0, sample_out}, {16'd0, e.data});
         end
      end
      if (sample_valid2) begin
         if (sq2.size() == 0) begin
            report_fail("unexpected_sample2", $sformatf("sample_out2 %0h", sample_out2));
         end else begin
            e = sq2.pop_front();
            check_output("decay_cycle", cyc, e.cyc);
            check_output("decay_data", {16'd0, sample_out2}, {16'd0, e.data});
         end
      end
   end

   task automatic apply_pluck(input bit with_tick);
      int p;
      logic [15:0] d;
      @(posedge clk); #1;
      pluck = 1'b1;
      sample_tick = with_tick;
      p = cyc;
      for (int i = 0; i < LEN; i++) begin
         d = {{2{mdl_lfsr[15]}}, mdl_lfsr[15:2]};
         wq.push_back('{p + 1 + i, 8'(i), d});
         exp_mem[i] = d;
         mdl_lfsr = model_step(mdl_lfsr);
      end
      exp_ptr = 0;
      @(posedge clk); #1;
      pluck = 1'b0;
      sample_tick = 1'b0;
   endtask

   task automatic apply_stimulus(input bit double_tick);
      int p, t;
      logic [15:0] y;
      p = exp_ptr;
      y = calc_y(exp_mem[(p == 0) ? LEN - 1 : p - 1], exp_mem[p]);
      @(posedge clk); #1;
      sample_tick = 1'b1;
      t = cyc;
      wq.push_back('{t + 2, 8'(p), y});
      sq.push_back('{t + 3, 8'(p), y});
      exp_mem[p] = y;
      exp_ptr = (p == LEN - 1) ? 0 : p + 1;
      @(posedge clk); #1;
      sample_tick = double_tick;
      @(posedge clk); #1;
      sample_tick = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic poke(input int addr, input logic [15:0] data);
      @(posedge clk); #1;
      poke_en = 1'b1;
      poke_addr = 8'(addr);
      poke_data = data;
      exp_mem[addr] = data;
      @(posedge clk); #1;
      poke_en = 1'b0;
   endtask

   task automatic wait_fill_done();
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (busy) report_fail("fill_timeout", "busy still high after 400 cycles");
   endtask

   initial begin : watchdog
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin : main
      int snap;
      int n;
      reset = 1'b0;
      pluck = 1'b0;
      sample_tick = 1'b0;
      pluck2 = 1'b0;
      tick2 = 1'b0;
      c800 = 16'd800;

      // Reset values.
      repeat (3) @(negedge clk);
      check_output("rst_rf_write", {31'd0, rf_write}, 32'd0);
      check_output("rst_rf_addr", {24'd0, rf_addr}, 32'd0);
      check_output("rst_rf_wdata", {16'd0, rf_wdata}, 32'd0);
      check_output("rst_sample_out", {16'd0, sample_out}, 32'd0);
      check_output("rst_sample_valid", {31'd0, sample_valid}, 32'd0);
      check_output("rst_overrun", {31'd0, overrun}, 32'd0);
      check_output("rst_busy", {31'd0, busy}, 32'd0);

      @(posedge clk); #1;
      reset = 1'b1;
      repeat (10) begin
         @(negedge clk);
         check_output("idle_busy", {31'd0, busy}, 32'd0);
         check_output("idle_rf_write", {31'd0, rf_write}, 32'd0);
      end

      // Tick in IDLE is ignored.
      @(posedge clk); #1;
      sample_tick = 1'b1;
      @(posedge clk); #1;
      sample_tick = 1'b0;
      repeat (3) @(negedge clk);
      check_output("idle_tick_overrun", {31'd0, overrun}, 32'd0);
      check_output("idle_sample_out", {16'd0, sample_out}, 32'd0);

      // Decay instance: fill, then one tick on 800/800 gives 700.
      @(posedge clk); #1;
      pluck2 = 1'b1;
      @(posedge clk); #1;
      pluck2 = 1'b0;
      repeat (LEN2 + 2) @(posedge clk);
      #1;
      tick2 = 1'b1;
      sq2.push_back('{cyc + 3, 8'd0, 16'd700});
      @(posedge clk); #1;
      tick2 = 1'b0;
      repeat (4) @(posedge clk);

      // Noise fill.
      snap = busy_cnt;
      apply_pluck(1'b0);
      @(negedge clk);
      check_output("first_fill_data", {16'd0, rf_wdata}, 32'h0000EB38);
      check_output("fill_busy", {31'd0, busy}, 32'd1);
      repeat (20) @(posedge clk);
      #1;
      sample_tick = 1'b1;
      @(posedge clk); #1;
      sample_tick = 1'b0;
      @(negedge clk);
      check_output("fill_tick_overrun", {31'd0, overrun}, 32'd1);
      wait_fill_done();
      check_output("fill_busy_cycles", busy_cnt - snap, LEN);
      check_output("fill_writes_drained", wq.size(), 0);

      // Ticks up to ptr 5, then the directed 100 / -50 case.
      for (int k = 0; k < 5; k++) apply_stimulus(1'b0);
      poke(4, 16'd100);
      poke(5, 16'hFFCE);
      apply_stimulus(1'b0);
      @(negedge clk);
      check_output("directed_sample_out", {16'd0, sample_out}, 32'd25);

      // Run to the last entry and wrap.
      while (exp_ptr != LEN - 1) apply_stimulus(1'b0);
      poke(0, 16'd300);
      apply_stimulus(1'b0);
      @(negedge clk);
      check_output("wrap_rf_addr", {24'd0, rf_addr}, 32'd0);
      apply_stimulus(1'b0);

      // Overrun stays set; pluck with a coincident tick clears it.
      check_output("overrun_sticky", {31'd0, overrun}, 32'd1);
      apply_pluck(1'b1);
      @(negedge clk);
      check_output("pluck_clears_overrun", {31'd0, overrun}, 32'd0);
      wait_fill_done();
      check_output("refill_overrun", {31'd0, overrun}, 32'd0);

      // Second tick landing in CALC is dropped and flags overrun.
      apply_stimulus(1'b1);
      @(negedge clk);
      check_output("calc_tick_overrun", {31'd0, overrun}, 32'd1);

      // Reset in the middle of a fill stops writes at once.
      apply_pluck(1'b0);
      repeat (20) @(posedge clk);
      #1;
      reset = 1'b0;
      wq.delete();
      mdl_lfsr = 16'hACE1;
      #1;
      check_output("reset_mid_fill_write", {31'd0, rf_write}, 32'd0);
      check_output("reset_mid_fill_busy", {31'd0, busy}, 32'd0);
      check_output("reset_mid_fill_addr", {24'd0, rf_addr}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (5) @(negedge clk);
      check_output("post_reset_overrun", {31'd0, overrun}, 32'd0);
      check_output("post_reset_busy", {31'd0, busy}, 32'd0);

      n = 0;
      while ((wq.size() + sq.size() + sq2.size()) != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_output("queues_drained", wq.size() + sq.size() + sq2.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/ks_voice_ctrl.md
KS_VOICE_CTRL -- requirements
Module: ks_voice_ctrl

Interface
REQ-001 Parameter LEN, default 218: delay-line length in samples.
REQ-002 Parameter DECAY_SH, default 0: decay shift; 0 disables decay.
REQ-003 Parameter AMP_SH, default 2: right-shift applied to noise during fill.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 pluck  in  1  one-cycle strobe that starts a new note (noise fill).
REQ-007 sample_tick  in  1  one-cycle audio-rate strobe requesting the next output sample.
REQ-008 rf_sample1  in  16  signed, delay-line entry at rf_addr-1 (entry LEN-1 when rf_addr==0).
REQ-009 rf_sample2  in  16  signed, delay-line entry at rf_addr.
REQ-010 rf_addr  out  8  delay-line read/write address.
REQ-011 rf_write  out  1  delay-line write enable, applied at rf_addr.
REQ-012 rf_wdata  out  16  delay-line write data.
REQ-013 sample_out  out  16  signed, last produced audio sample (held between updates).
REQ-014 sample_valid  out  1  one-cycle pulse when sample_out updates.
REQ-015 busy  out  1  high while in FILL.
REQ-016 overrun  out  1  sticky flag: a sample_tick was dropped.

Function
REQ-017 The FSM SHALL have the states IDLE, FILL, WAIT, CALC and WRITE.
REQ-018 IDLE: on pluck, go to FILL with ptr=0; sample_tick SHALL be ignored and SHALL NOT set overrun.
REQ-019 FILL: each cycle, rf_addr=ptr, rf_write=1, rf_wdata=lfsr>>>AMP_SH (arithmetic), then advance the LFSR.
REQ-020 FILL: when ptr==LEN-1, write that entry, set ptr=0 and go to WAIT; the fill takes exactly LEN cycles.
REQ-021 WAIT: rf_addr=ptr and rf_write=0; on sample_tick, go to CALC.
REQ-022 CALC: register avg=(sext17(rf_sample1)+sext17(rf_sample2))>>>1, truncated to 16 bits.
REQ-023 CALC: then register y=avg-(avg>>>DECAY_SH) when DECAY_SH>0, else y=avg; go to WRITE.
REQ-024 WRITE: rf_write=1, rf_addr=ptr, rf_wdata=y; sample_out<=y with sample_valid pulsed for the next cycle.
REQ-025 WRITE: ptr SHALL advance, wrapping from LEN-1 to 0; then go to WAIT.
REQ-026 Latency: sample_tick at cycle t SHALL produce sample_valid at cycle t+3, and the write SHALL occur during cycle t+2.
REQ-027 A sample_tick in FILL, CALC or WRITE SHALL be dropped and SHALL set overrun; overrun clears only on pluck or reset.
REQ-028 A pluck in any state SHALL restart FILL at ptr=0 and clear overrun; an in-flight CALC or WRITE is abandoned with no write.
REQ-029 If pluck and sample_tick coincide, pluck SHALL win, and the tick is dropped without setting overrun.
REQ-030 rf_write SHALL be 0 in IDLE, WAIT and CALC.
REQ-031 The LFSR SHALL be a 16-bit Galois LFSR with mask 16'hB400, shifting right, advancing only in FILL; it is not reseeded on pluck.
REQ-032 busy SHALL be high exactly in FILL.

Reset
REQ-033 While reset is low: state=IDLE, ptr=0, lfsr=16'hACE1, sample_out=0, sample_valid=0, overrun=0, rf_write=0, rf_addr=0, rf_wdata=0.
REQ-034 Reset assertion mid-FILL or mid-WRITE SHALL take effect immediately, with no further writes.

Structure
REQ-035 Shared package ks_pkg SHALL hold SAMPLE_W=16, ADDR_W=8, default LEN, LFSR mask/seed constants and the state enum type.
REQ-036 The LFSR SHALL be the sub-module ks_noise_lfsr, with inputs clk, reset, advance and output value[15:0].
REQ-037 The pointer, FSM and datapath SHALL be in ks_voice_ctrl; the target is 120-400 lines of RTL.

Verification
REQ-038 Reset then release, no stimulus -> all outputs 0, busy=0, rf_write never 1.
REQ-039 Pluck -> busy for 218 cycles, writes to addresses 0..217 in order; first rf_wdata=16'hEB38.
REQ-040 In WAIT with ptr=5, rf_sample1=100, rf_sample2=-50, tick at t -> write of 25 to address 5 at t+2, sample_out=25 with sample_valid at t+3.
REQ-041 DECAY_SH=3, inputs 800/800 -> y=700.
REQ-042 ptr=217 and a tick -> write at 217, then ptr=0; next tick reads entries 217/0 via rf_sample1/rf_sample2.
REQ-043 Tick during FILL -> overrun=1; pluck mid-WAIT -> overrun=0 and the fill restarts at address 0; reset low mid-FILL -> rf_write=0 immediately.
